// File: rtl/rom_program_sequencer.sv
// ---------------------------------------------------------------------------
// rom_program_sequencer
//
// Sequencer for ROM-mode CPU operation. It holds a small writable program
// memory and fetches one instruction at a time. For each instruction it drives
// operands and an opcode into the mode switch that feeds the ALU. It then waits
// a fixed ALU latency, captures the ALU result and advances the program
// counter. Execution stops on a halt instruction, at the end of memory, on a
// stop request, or when mode falls to 0.
//
// Optional feature (compile-time macro SEQ_ACCUM_EN):
//   When defined, an instruction with use_acc=1 takes operand A from the last
//   captured result instead of its own a field, so results can be chained.
//   When undefined, the use_acc bit is ignored.
//
// Instruction word: [20] halt, [19] use_acc, [18:16] opcode, [15:8] a, [7:0] b
//
// Ports:
//   clk           clock; all state updates on the rising edge
//   rst_n         synchronous active-low reset
//   mode          1 = ROM execution enabled (same as the switch select)
//   start         pulse; begin execution at address 0
//   stop          pulse; abort execution
//   prog_we       program-memory write enable (honoured in IDLE/DONE only)
//   prog_addr     program write address
//   prog_data     instruction word to write
//   alu_result    ALU output
//   cpu_a/cpu_b   operands to the switch
//   cpu_opcode    opcode to the switch
//   issue         one-cycle pulse on the first cycle of valid operands
//   result_out    last captured ALU result
//   result_valid  one-cycle pulse when result_out updates
//   pc            current program counter
//   busy          high in FETCH, ISSUE and WAIT
//   done          high in DONE
//
// States:
//   IDLE  | waiting for start with mode=1
//   FETCH | read mem[pc]; a halt word ends the program
//   ISSUE | operands valid, issue pulse high
//   WAIT  | counting down the ALU latency
//   DONE  | program finished; outputs hold
// ---------------------------------------------------------------------------
module rom_program_sequencer #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int ALU_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              start,
    input  logic              stop,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [20:0]       prog_data,
    input  logic [7:0]        alu_result,
    output logic [7:0]        cpu_a,
    output logic [7:0]        cpu_b,
    output logic [2:0]        cpu_opcode,
    output logic              issue,
    output logic [7:0]        result_out,
    output logic              result_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0]        LAT  = 3'(ALU_LAT);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t      state;
    state_t      state_nxt;
    logic [20:0] mem [DEPTH];
    logic [20:0] fetch_word;
    logic [7:0]  op_a;
    logic [2:0]  wait_cnt;
    logic        abort;
    logic        capture;
    logic        load_ops;
    logic        restart;

    assign fetch_word = mem[pc];
    assign abort      = stop || !mode;

`ifdef SEQ_ACCUM_EN
    assign op_a = fetch_word[19] ? result_out : fetch_word[15:8];
`else
    logic unused_use_acc;
    assign op_a           = fetch_word[15:8];
    assign unused_use_acc = fetch_word[19];
`endif

    // Writes are accepted only while the sequencer is not running, so the
    // word currently being fetched can never change underneath it.
    always_ff @(posedge clk) begin
        if (prog_we && (state == S_IDLE || state == S_DONE)) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        load_ops  = 1'b0;
        restart   = 1'b0;
        case (state)
            S_IDLE: begin
                // stop wins over a simultaneous start
                if (start && mode && !stop) begin
                    state_nxt = S_FETCH;
                    restart   = 1'b1;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (fetch_word[20]) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_ISSUE;
                    load_ops  = 1'b1;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (LAT == 3'd0) begin
                    capture = 1'b1;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (wait_cnt == 3'd1) begin
                    capture = 1'b1;
                end
            end
            S_DONE: begin
                if (!mode) begin
                    state_nxt = S_IDLE;
                end else if (start) begin
                    state_nxt = S_FETCH;
                    restart   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // End of memory stops execution rather than wrapping to address 0.
        if (capture) begin
            state_nxt = (pc == LAST) ? S_DONE : S_FETCH;
        end
    end

    // Operands are registered on the FETCH->ISSUE edge so they are valid for
    // the whole ISSUE cycle and hold until the next instruction is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc           <= '0;
            cpu_a        <= '0;
            cpu_b        <= '0;
            cpu_opcode   <= '0;
            result_out   <= '0;
            issue        <= 1'b0;
            result_valid <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            issue        <= load_ops;
            result_valid <= capture;
            if (restart) begin
                pc <= '0;
            end else if (capture && pc != LAST) begin
                pc <= pc + 1'b1;
            end
            if (load_ops) begin
                cpu_a      <= op_a;
                cpu_b      <= fetch_word[7:0];
                cpu_opcode <= fetch_word[18:16];
            end
            if (capture) begin
                result_out <= alu_result;
            end
            if (state == S_ISSUE) begin
                wait_cnt <= LAT;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
        end
    end

    assign busy = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_rom_program_sequencer.sv
// ---------------------------------------------------------------------------
// Directed testbench for rom_program_sequencer. Three instances with ALU
// latency 0, 3 and 2 share the program-write bus. Each instance has its own
// mode, start and stop controls and its own ALU model (add / subtract).
// ---------------------------------------------------------------------------
module tb_rom_program_sequencer;

    localparam int N = 3;

    logic        clk;
    logic        rst_n;
    logic        mode      [N];
    logic        start     [N];
    logic        stop      [N];
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [20:0] prog_data;
    logic [7:0]  alu_res   [N];
    logic [7:0]  cpu_a     [N];
    logic [7:0]  cpu_b     [N];
    logic [2:0]  cpu_op    [N];
    logic        issue     [N];
    logic [7:0]  res_out   [N];
    logic        res_vld   [N];
    logic [3:0]  pc        [N];
    logic        busy      [N];
    logic        done      [N];

    int n_chk  = 0;
    int n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_res[0] = alu_f(cpu_a[0], cpu_b[0], cpu_op[0]);
    assign alu_res[1] = alu_f(cpu_a[1], cpu_b[1], cpu_op[1]);
    assign alu_res[2] = alu_f(cpu_a[2], cpu_b[2], cpu_op[2]);

    rom_program_sequencer #(.DEPTH(16), .ADDR_W(4), .ALU_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .mode(mode[0]), .start(start[0]), .stop(stop[0]),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .alu_result(alu_res[0]), .cpu_a(cpu_a[0]), .cpu_b(cpu_b[0]),
        .cpu_opcode(cpu_op[0]), .issue(issue[0]), .result_out(res_out[0]),
        .result_valid(res_vld[0]), .pc(pc[0]), .busy(busy[0]), .done(done[0]));

    rom_program_sequencer #(.DEPTH(16), .ADDR_W(4), .ALU_LAT(3)) u1 (
        .clk(clk), .rst_n(rst_n), .mode(mode[1]), .start(start[1]), .stop(stop[1]),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .alu_result(alu_res[1]), .cpu_a(cpu_a[1]), .cpu_b(cpu_b[1]),
        .cpu_opcode(cpu_op[1]), .issue(issue[1]), .result_out(res_out[1]),
        .result_valid(res_vld[1]), .pc(pc[1]), .busy(busy[1]), .done(done[1]));

    rom_program_sequencer #(.DEPTH(16), .ADDR_W(4), .ALU_LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .mode(mode[2]), .start(start[2]), .stop(stop[2]),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .alu_result(alu_res[2]), .cpu_a(cpu_a[2]), .cpu_b(cpu_b[2]),
        .cpu_opcode(cpu_op[2]), .issue(issue[2]), .result_out(res_out[2]),
        .result_valid(res_vld[2]), .pc(pc[2]), .busy(busy[2]), .done(done[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] addr, input logic [20:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    // After this returns the start edge has been taken: the instance is in FETCH.
    task automatic go(input int i);
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam logic [20:0] HALT = 21'h100000;

    initial begin
        int npulse;
        int nbad;
        logic [7:0] exp_r2;
        logic [7:0] exp_a2;

        rst_n     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        for (int i = 0; i < N; i++) begin
            mode[i]  = 1'b0;
            start[i] = 1'b0;
            stop[i]  = 1'b0;
        end
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_pc",      32'(pc[0]), 0);
        chk("rst_busy",    32'(busy[0]), 0);
        chk("rst_done",    32'(done[0]), 0);
        chk("rst_issue",   32'(issue[0]), 0);
        chk("rst_rvalid",  32'(res_vld[0]), 0);
        chk("rst_result",  32'(res_out[0]), 0);
        chk("rst_cpu_a",   32'(cpu_a[0]), 0);

        // 5+3 then halt, ALU_LAT=0
        write_word(4'd0, 21'h000503);
        write_word(4'd1, HALT);
        mode[0] = 1'b1;
        go(0);
        chk("t2_fetch_busy", 32'(busy[0]), 1);
        chk("t2_fetch_issue", 32'(issue[0]), 0);
        tick();
        chk("t2_issue",  32'(issue[0]), 1);
        chk("t2_pc",     32'(pc[0]), 0);
        chk("t2_cpu_a",  32'(cpu_a[0]), 32'h05);
        chk("t2_cpu_b",  32'(cpu_b[0]), 32'h03);
        tick();
        chk("t2_rvalid", 32'(res_vld[0]), 1);
        chk("t2_result", 32'(res_out[0]), 32'h08);
        tick();
        chk("t2_done",   32'(done[0]), 1);
        chk("t2_busy",   32'(busy[0]), 0);
        chk("t2_pc_end", 32'(pc[0]), 1);

        // Same program, ALU_LAT=3: result_valid 5 cycles after FETCH
        mode[1] = 1'b1;
        go(1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("t3_rvalid_low_%0d", k), 32'(res_vld[1]), 0);
            chk($sformatf("t3_cpu_a_%0d", k), 32'(cpu_a[1]), 32'h05);
            chk($sformatf("t3_issue_%0d", k), 32'(issue[1]), (k == 1) ? 1 : 0);
        end
        tick();
        chk("t3_rvalid", 32'(res_vld[1]), 1);
        chk("t3_result", 32'(res_out[1]), 32'h08);
        tick();
        chk("t3_done",   32'(done[1]), 1);

        // Sixteen non-halt words: sixteen results, done at pc=15, no wrap
        for (int a = 0; a < 16; a++) write_word(4'(a), 21'h000101);
        go(0);
        npulse = 0;
        nbad   = 0;
        for (int c = 0; c < 100 && !done[0]; c++) begin
            tick();
            if (res_vld[0]) begin
                npulse++;
                if (res_out[0] !== 8'h02) nbad++;
            end
        end
        chk("t4_done",    32'(done[0]), 1);
        chk("t4_pulses",  32'(npulse), 16);
        chk("t4_bad_val", 32'(nbad), 0);
        chk("t4_pc",      32'(pc[0]), 15);
        tick();
        tick();
        chk("t4_pc_hold", 32'(pc[0]), 15);
        chk("t4_rvalid_after", 32'(res_vld[0]), 0);

        // ALU_LAT=2: stop on the last WAIT cycle of instruction 2
        mode[2] = 1'b1;
        go(2);
        for (int k = 0; k < 11; k++) tick();
        chk("t5_pc_before", 32'(pc[2]), 2);
        chk("t5_busy_before", 32'(busy[2]), 1);
        stop[2]   = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = HALT;
        tick();
        stop[2] = 1'b0;
        prog_we = 1'b0;
        chk("t5_idle_busy", 32'(busy[2]), 0);
        chk("t5_idle_done", 32'(done[2]), 0);
        chk("t5_rvalid",    32'(res_vld[2]), 0);
        chk("t5_pc",        32'(pc[2]), 2);
        tick();
        chk("t5_rvalid2",   32'(res_vld[2]), 0);
        go(2);
        tick();
        chk("t5_mem0_kept_issue", 32'(issue[2]), 1);
        chk("t5_mem0_kept_b",     32'(cpu_b[2]), 32'h01);
        stop[2] = 1'b1;
        tick();
        stop[2] = 1'b0;
        chk("t5_stop_issue", 32'(busy[2]), 0);

        // mode=0 start ignored, mode drop in ISSUE, wrap-around add
        write_word(4'd0, 21'h00FF02);
        write_word(4'd1, HALT);
        mode[0] = 1'b0;
        tick();
        chk("t6_done_to_idle", 32'(done[0]), 0);
        go(0);
        tick();
        chk("t6_start_ignored", 32'(busy[0]), 0);
        mode[0] = 1'b1;
        go(0);
        tick();
        chk("t6_issue",  32'(issue[0]), 1);
        chk("t6_cpu_a",  32'(cpu_a[0]), 32'hFF);
        mode[0] = 1'b0;
        tick();
        mode[0] = 1'b1;
        chk("t6_abort_busy",   32'(busy[0]), 0);
        chk("t6_abort_rvalid", 32'(res_vld[0]), 0);
        chk("t6_abort_result", 32'(res_out[0]), 32'h02);
        chk("t6_abort_pc",     32'(pc[0]), 0);
        chk("t6_abort_cpu_a",  32'(cpu_a[0]), 32'hFF);
        start[0] = 1'b1;
        stop[0]  = 1'b1;
        tick();
        start[0] = 1'b0;
        stop[0]  = 1'b0;
        chk("t6_start_stop", 32'(busy[0]), 0);
        go(0);
        tick();
        tick();
        chk("t6_rvalid", 32'(res_vld[0]), 1);
        chk("t6_wrap",   32'(res_out[0]), 32'h01);
        tick();
        chk("t6_done",   32'(done[0]), 1);

        // Accumulate chain: 10+20, then (acc or 99)-5
`ifdef SEQ_ACCUM_EN
        exp_a2 = 8'h1E;
        exp_r2 = 8'h19;
`else
        exp_a2 = 8'h63;
        exp_r2 = 8'h5E;
`endif
        write_word(4'd0, 21'h000A14);
        write_word(4'd1, 21'h096305);
        write_word(4'd2, HALT);
        go(0);
        tick();
        chk("t7_cpu_a1", 32'(cpu_a[0]), 32'h0A);
        tick();
        chk("t7_rvalid1", 32'(res_vld[0]), 1);
        chk("t7_result1", 32'(res_out[0]), 32'h1E);
        tick();
        chk("t7_cpu_a2", 32'(cpu_a[0]), 32'(exp_a2));
        tick();
        chk("t7_rvalid2", 32'(res_vld[0]), 1);
        chk("t7_result2", 32'(res_out[0]), 32'(exp_r2));
        tick();
        chk("t7_done",    32'(done[0]), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
